// File: rtl/lsu_stage_if.sv
// lsu_stage_if: request, data-bus, writeback and fault signals of the
// load/store stage. The execute stage / memory model side uses "master",
// the LSU itself uses "slave". Data width mirrors XLEN from defines.vh.
interface lsu_stage_if;
  localparam int XLEN = 32;

  // execute-stage request
  logic            req_valid;
  logic            req_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd;

  // data bus
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  // writeback, fault, stall
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            fault;
  logic [XLEN-1:0] fault_addr;
  logic            busy;

  modport master (
    output req_valid, opcode, funct3, addr, store_data, rd, dmem_ack, dmem_rdata,
    input  req_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  wb_valid, wb_rd, wb_data, fault, fault_addr, busy
  );

  modport slave (
    input  req_valid, opcode, funct3, addr, store_data, rd, dmem_ack, dmem_rdata,
    output req_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output wb_valid, wb_rd, wb_data, fault, fault_addr, busy
  );
endinterface

// File: rtl/lsu_stage.sv
// lsu_stage: single-outstanding load/store unit. IDLE accepts a request,
// BUS holds a data-bus access until ack (or timeout), RESP writes a load back.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault on misaligned
// half/word accesses; otherwise the low address bits are cleared to the
// access size and the access proceeds.
module lsu_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic       clk,
  input logic       rst_n,
  lsu_stage_if.slave bus
);
  localparam int XLEN = 32;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          state_reg;
  logic [7:0]      wait_cnt_reg;
  logic            is_load_reg;
  logic [2:0]      funct3_reg;
  logic [1:0]      offset_reg;
  logic [XLEN-1:0] addr_reg;
  logic [4:0]      rd_reg;

  logic            is_load;
  logic            is_store;
  logic            f3_legal;
  logic            addr_legal;
  logic            size_half;
  logic            size_word;
  logic [1:0]      offset_next;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);

  // Decode the presented request: kind, funct3 legality and access size.
  always_comb begin
    is_load   = (bus.opcode == OP_LOAD);
    is_store  = (bus.opcode == OP_STORE);
    size_half = (bus.funct3[1:0] == 2'b01);
    size_word = (bus.funct3[1:0] == 2'b10);
    f3_legal  = 1'b0;
    if (is_load) begin
      f3_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b101);
    end else if (is_store) begin
      f3_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
    end
  end

  // Alignment policy: trap on misalignment, or silently clear the low bits.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    addr_legal = !((size_half && bus.addr[0]) || (size_word && (bus.addr[1:0] != 2'b00)));
`else
    addr_legal = 1'b1;
`endif
    if (size_word)      offset_next = 2'b00;
    else if (size_half) offset_next = {bus.addr[1], 1'b0};
    else                offset_next = bus.addr[1:0];
  end

  // Byte enables follow the (aligned) access size and offset.
  always_comb begin
    if (size_word)      be_next = 4'b1111;
    else if (size_half) be_next = 4'b0011 << offset_next;
    else                be_next = 4'b0001 << offset_next;
  end

  // Store data lanes: byte replicated x4, half replicated x2, word as-is.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_next[8*gi +: 8] =
        (bus.funct3[1:0] == 2'b00) ? bus.store_data[7:0] :
        (bus.funct3[1:0] == 2'b01) ? bus.store_data[8*(gi % 2) +: 8] :
                                     bus.store_data[8*gi +: 8];
  end

  // Load extraction from the returned word using the latched size/offset.
  always_comb begin
    ld_byte = bus.dmem_rdata[{offset_reg, 3'b000} +: 8];
    ld_half = offset_reg[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (funct3_reg)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = bus.dmem_rdata;
    endcase
  end

  // Control FSM with registered bus, writeback and fault outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 8'd0;
      is_load_reg    <= 1'b0;
      funct3_reg     <= 3'b000;
      offset_reg     <= 2'b00;
      addr_reg       <= '0;
      rd_reg         <= 5'd0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_be    <= 4'b0000;
      bus.wb_valid   <= 1'b0;
      bus.wb_rd      <= 5'd0;
      bus.wb_data    <= '0;
      bus.fault      <= 1'b0;
      bus.fault_addr <= '0;
    end else begin
      // wb_valid and fault are single-cycle pulses
      bus.wb_valid <= 1'b0;
      bus.fault    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid && (is_load || is_store)) begin
            if (f3_legal && addr_legal) begin
              state_reg      <= BUS;
              wait_cnt_reg   <= 8'd0;
              is_load_reg    <= is_load;
              funct3_reg     <= bus.funct3;
              offset_reg     <= offset_next;
              addr_reg       <= bus.addr;
              rd_reg         <= bus.rd;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= is_store;
              bus.dmem_addr  <= {bus.addr[XLEN-1:2], 2'b00};
              bus.dmem_wdata <= is_store ? wdata_next : '0;
              bus.dmem_be    <= be_next;
            end else begin
              bus.fault      <= 1'b1;
              bus.fault_addr <= bus.addr;
            end
          end
        end
        BUS: begin
          if (bus.dmem_ack) begin
            state_reg    <= RESP;
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            if (is_load_reg) begin
              bus.wb_valid <= 1'b1;
              bus.wb_rd    <= rd_reg;
              bus.wb_data  <= load_data;
            end
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg      <= IDLE;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.fault      <= 1'b1;
            bus.fault_addr <= addr_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        RESP: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed load/store vectors with hand-computed results.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-word case.
module tb_lsu_stage;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lsu_stage_if bus();

  lsu_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // observations gathered by mem_op
  int          n_req, n_wb, n_fault, first_req_c, wb_c, fault_c;
  logic        unstable, ready_in_bus, ready_after_fault;
  logic        seen_we;
  logic [3:0]  seen_be;
  logic [31:0] seen_addr, seen_wdata, seen_wb_data, seen_fault_addr;
  logic [4:0]  seen_wb_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and act as the memory: ack after ack_delay extra
  // dmem_req cycles (negative = never). Watches max_cycles cycles.
  task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] r, input logic [31:0] rdata,
                        input int ack_delay, input int max_cycles);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.opcode = op; bus.funct3 = f3;
    bus.addr = a; bus.store_data = sd; bus.rd = r;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n_req = 0; n_wb = 0; n_fault = 0; first_req_c = -1; wb_c = -1; fault_c = -1;
    unstable = 1'b0; ready_in_bus = 1'b0; ready_after_fault = 1'b0;
    seen_we = 1'b0; seen_be = 4'h0; seen_addr = '0; seen_wdata = '0;
    seen_wb_data = '0; seen_wb_rd = '0; seen_fault_addr = '0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      if (bus.dmem_req) begin
        if (n_req == 0) begin
          first_req_c = c; seen_addr = bus.dmem_addr; seen_we = bus.dmem_we;
          seen_be = bus.dmem_be; seen_wdata = bus.dmem_wdata; ready_in_bus = bus.req_ready;
        end else if (bus.dmem_addr !== seen_addr || bus.dmem_we !== seen_we ||
                     bus.dmem_be !== seen_be || bus.dmem_wdata !== seen_wdata) begin
          unstable = 1'b1;
        end
        n_req++;
        if (ack_delay >= 0 && n_req == ack_delay + 1) begin
          bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
        end
      end
      if (bus.wb_valid) begin
        n_wb++; wb_c = c; seen_wb_data = bus.wb_data; seen_wb_rd = bus.wb_rd;
      end
      if (fault_c >= 0 && c == fault_c + 1) ready_after_fault = bus.req_ready;
      if (bus.fault) begin
        n_fault++; fault_c = c; seen_fault_addr = bus.fault_addr;
      end
    end
    bus.dmem_ack = 1'b0;
  endtask

  task automatic expect_load(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] rdata, input logic [4:0] r,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
    mem_op(op, f3, a, 32'h0, r, rdata, 2, 8);
    check_eq({tag, "_req_cycles"}, n_req, 3);
    check_eq({tag, "_req_latency"}, first_req_c, 0);
    check_eq({tag, "_addr"}, seen_addr, exp_addr);
    check_eq({tag, "_we"}, seen_we, 1'b0);
    check_eq({tag, "_stable"}, unstable, 1'b0);
    check_eq({tag, "_ready_in_bus"}, ready_in_bus, 1'b0);
    check_eq({tag, "_wb_count"}, n_wb, 1);
    check_eq({tag, "_wb_latency"}, wb_c, 3);
    check_eq({tag, "_wb_data"}, seen_wb_data, exp_data);
    check_eq({tag, "_wb_rd"}, seen_wb_rd, r);
    check_eq({tag, "_fault_count"}, n_fault, 0);
  endtask

  task automatic expect_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    mem_op(OP_STORE, f3, a, sd, 5'd0, 32'h0, 0, 6);
    check_eq({tag, "_req_cycles"}, n_req, 1);
    check_eq({tag, "_we"}, seen_we, 1'b1);
    check_eq({tag, "_addr"}, seen_addr, exp_addr);
    check_eq({tag, "_be"}, seen_be, exp_be);
    check_eq({tag, "_wdata"}, seen_wdata, exp_wdata);
    check_eq({tag, "_wb_count"}, n_wb, 0);
    check_eq({tag, "_fault_count"}, n_fault, 0);
  endtask

  task automatic expect_fault(input string tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] a);
    mem_op(op, f3, a, 32'h0, 5'd1, 32'h0, 0, 4);
    check_eq({tag, "_req_cycles"}, n_req, 0);
    check_eq({tag, "_fault_count"}, n_fault, 1);
    check_eq({tag, "_fault_cycle"}, fault_c, 0);
    check_eq({tag, "_fault_addr"}, seen_fault_addr, a);
    check_eq({tag, "_wb_count"}, n_wb, 0);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int late_wb, late_fault, late_req;
    bus.req_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.addr = '0;
    bus.store_data = '0; bus.rd = '0; bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_dmem_req", bus.dmem_req, 1'b0);
    check_eq("rst_dmem_addr", bus.dmem_addr, 32'h0);
    check_eq("rst_wb_valid", bus.wb_valid, 1'b0);
    check_eq("rst_fault", bus.fault, 1'b0);
    rst_n = 1'b1;

    // loads: sign/zero extension and lane selection
    expect_load("lb_103",  OP_LOAD, 3'b000, 32'h0000_0103, 32'h80FF_1234, 5'd7,  32'h0000_0100, 32'hFFFF_FF80);
    expect_load("lh_106",  OP_LOAD, 3'b001, 32'h0000_0106, 32'h8001_7FFF, 5'd9,  32'h0000_0104, 32'hFFFF_8001);
    expect_load("lhu_106", OP_LOAD, 3'b101, 32'h0000_0106, 32'h8001_7FFF, 5'd10, 32'h0000_0104, 32'h0000_8001);
    expect_load("lbu_101", OP_LOAD, 3'b100, 32'h0000_0101, 32'h0000_AB00, 5'd11, 32'h0000_0100, 32'h0000_00AB);
    expect_load("lw_108",  OP_LOAD, 3'b010, 32'h0000_0108, 32'hDEAD_BEEF, 5'd31, 32'h0000_0108, 32'hDEAD_BEEF);

    // stores: byte enables and lane replication
    expect_store("sh_202", 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    expect_store("sb_101", 3'b000, 32'h0000_0101, 32'h1234_5678, 32'h0000_0100, 4'b0010, 32'h7878_7878);
    expect_store("sw_104", 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'h0000_0104, 4'b1111, 32'hCAFE_F00D);

    // illegal funct3 faults without bus activity
    expect_fault("ld_f3_011", OP_LOAD,  3'b011, 32'h0000_0400);
    expect_fault("st_f3_100", OP_STORE, 3'b100, 32'h0000_0404);

    // non-memory opcode is consumed silently
    mem_op(OP_ALU, 3'b000, 32'h0000_0500, 32'h0, 5'd3, 32'h0, 0, 4);
    check_eq("alu_req_cycles", n_req, 0);
    check_eq("alu_wb_count", n_wb, 0);
    check_eq("alu_fault_count", n_fault, 0);

    // misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
    expect_fault("lw_101_trap", OP_LOAD, 3'b010, 32'h0000_0101);
`else
    expect_load("lw_101_align", OP_LOAD, 3'b010, 32'h0000_0101, 32'h1122_3344, 5'd4, 32'h0000_0100, 32'h1122_3344);
`endif

    // timeout with TIMEOUT_CYCLES=4
    mem_op(OP_LOAD, 3'b010, 32'h0000_0300, 32'h0, 5'd6, 32'h0, -1, 8);
    check_eq("tmo_req_cycles", n_req, 4);
    check_eq("tmo_fault_count", n_fault, 1);
    check_eq("tmo_fault_cycle", fault_c, 4);
    check_eq("tmo_fault_addr", seen_fault_addr, 32'h0000_0300);
    check_eq("tmo_wb_count", n_wb, 0);
    check_eq("tmo_ready_after", ready_after_fault, 1'b1);

    // ack while idle is ignored
    @(negedge clk);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check_eq("idle_ack_wb", bus.wb_valid, 1'b0);
    check_eq("idle_ack_busy", bus.busy, 1'b0);
    bus.dmem_ack = 1'b0;

    // reset in the middle of BUS, then a late ack
    @(negedge clk);
    bus.req_valid = 1'b1; bus.opcode = OP_LOAD; bus.funct3 = 3'b010; bus.addr = 32'h0000_0600; bus.rd = 5'd8;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_req_before", bus.dmem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req_drop", bus.dmem_req, 1'b0);
    check_eq("mid_rst_busy", bus.busy, 1'b0);
    check_eq("mid_rst_addr", bus.dmem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_5555;
    late_wb = 0; late_fault = 0; late_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.wb_valid) late_wb++;
      if (bus.fault) late_fault++;
      if (bus.dmem_req) late_req++;
    end
    bus.dmem_ack = 1'b0;
    check_eq("late_ack_wb", late_wb, 0);
    check_eq("late_ack_fault", late_fault, 0);
    check_eq("late_ack_req", late_req, 0);
    expect_load("lbu_after_rst", OP_LOAD, 3'b100, 32'h0000_0200, 32'h0000_00AB, 5'd12, 32'h0000_0200, 32'h0000_00AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
